// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg: shared types and constants for the register-file write-port arbiter.
//   wb_state_e : arbiter FSM states (IDLE, WAIT)
//   wb_gnt_e   : which source owns the write port this cycle
//   DATA_W_DEF / NUM_W_DEF : default widths
//   REG_ZERO / REG_RA      : hard-wired zero register and link register numbers
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NUM_W_DEF  = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic {
    IDLE,
    WAIT
  } wb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_P,
    GNT_M
  } wb_gnt_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_if: bundle of the pipeline writeback source (p_*), the
// multi-cycle unit source (m_*) and the register-file write port (rf_*).
//   slave  : arbiter view (takes p_/m_ requests, drives stall/ack and rf_*)
//   master : environment view (drives p_/m_ requests, observes the rest)
// -----------------------------------------------------------------------------
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int NUM_W  = 5
);
  logic              p_valid;
  logic [NUM_W-1:0]  p_num;
  logic [DATA_W-1:0] p_data;
  logic              p_stall;
  logic              m_req;
  logic [NUM_W-1:0]  m_num;
  logic [DATA_W-1:0] m_data;
  logic              m_ack;
  logic              rf_we;
  logic [NUM_W-1:0]  rf_num;
  logic [DATA_W-1:0] rf_data;

  modport slave (
    input  p_valid, p_num, p_data, m_req, m_num, m_data,
    output p_stall, m_ack, rf_we, rf_num, rf_data
  );

  modport master (
    output p_valid, p_num, p_data, m_req, m_num, m_data,
    input  p_stall, m_ack, rf_we, rf_num, rf_data
  );
endinterface

// File: rtl/wb_port_arbiter_starve_cnt.sv
// -----------------------------------------------------------------------------
// wb_starve_cnt: up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   i_inc    : count up one this cycle
//   i_clr    : clear to zero (wins over i_inc)
//   o_cnt    : current count
//   o_sat    : count has reached MAX (only when SAT=1)
// With SAT=1 the count sticks at MAX; with SAT=0 it wraps at 2^W.
// -----------------------------------------------------------------------------
module wb_starve_cnt #(
  parameter int W   = 3,
  parameter int MAX = 4,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_sat
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = SAT && (r_cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = w_at_max;

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter: shares the single register-file write port between the
// in-order pipeline writeback (P) and a late multi-cycle unit (M).
//   clk, rst  : clock, synchronous active-high reset
//   bus.p_*   : pipeline write (held by the pipeline while p_stall=1)
//   bus.m_*   : multi-cycle write request (held until m_ack)
//   bus.p_stall, bus.m_ack : combinational grant feedback
//   bus.rf_*  : registered register-file write port (latency 1)
//   force_cnt : cycles with p_stall=1, only when WB_STATS_EN is defined
// P wins by default. M is forced through when it targets the same register as
// P (older value must land first) or after MAX_WAIT consecutive blocked cycles.
// Writes to register 0 are granted normally but never assert rf_we.
// -----------------------------------------------------------------------------
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_W    = NUM_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef WB_STATS_EN
  output logic [31:0] force_cnt,
`endif
  wb_port_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  wb_state_e  r_state, w_state_nxt;
  wb_gnt_e    w_gnt;
  logic       w_conflict, w_force, w_stall;
  logic       w_cnt_inc, w_cnt_clr, w_wait_sat;
  logic [CNT_W-1:0] w_wait_cnt;

  logic              r_rf_we_p1;
  logic [NUM_W-1:0]  r_rf_num_p1;
  logic [DATA_W-1:0] r_rf_data_p1;

  wb_starve_cnt #(
    .W   (CNT_W),
    .MAX (MAX_WAIT),
    .SAT (1'b1)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_cnt_inc),
    .i_clr (w_cnt_clr),
    .o_cnt (w_wait_cnt),
    .o_sat (w_wait_sat)
  );

  // Same-register ordering: M carries the older value, so it must land first.
  // Register 0 is excluded since neither write is architecturally visible.
  assign w_conflict = bus.p_valid && bus.m_req &&
                      (bus.p_num == bus.m_num) && (bus.m_num != '0);

  assign w_force = bus.m_req && bus.p_valid && (r_state == WAIT) &&
                   (w_wait_cnt == CNT_W'(MAX_WAIT));

  always_comb begin
    w_gnt   = GNT_NONE;
    w_stall = 1'b0;
    if (!rst) begin
      if (w_conflict || w_force) begin
        w_gnt   = GNT_M;
        w_stall = 1'b1;
      end else if (bus.p_valid) begin
        w_gnt = GNT_P;
      end else if (bus.m_req) begin
        w_gnt = GNT_M;
      end
    end
  end

  assign bus.p_stall = w_stall;
  assign bus.m_ack   = (w_gnt == GNT_M);

  // FSM next state and wait-counter control. Any cycle where M is requesting
  // but not granted is a blocked cycle; the counter saturates at MAX_WAIT.
  always_comb begin
    w_state_nxt = IDLE;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    if (w_gnt == GNT_M) begin
      w_cnt_clr = 1'b1;
    end else if (bus.m_req) begin
      w_state_nxt = WAIT;
      w_cnt_inc   = !w_wait_sat;
    end else begin
      w_cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- stage p1: registered register-file write port ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we_p1   <= 1'b0;
      r_rf_num_p1  <= '0;
      r_rf_data_p1 <= '0;
    end else begin
      case (w_gnt)
        GNT_P: begin
          r_rf_we_p1   <= (bus.p_num != '0);
          r_rf_num_p1  <= bus.p_num;
          r_rf_data_p1 <= bus.p_data;
        end
        GNT_M: begin
          r_rf_we_p1   <= (bus.m_num != '0);
          r_rf_num_p1  <= bus.m_num;
          r_rf_data_p1 <= bus.m_data;
        end
        default: begin
          r_rf_we_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rf_we   = r_rf_we_p1;
  assign bus.rf_num  = r_rf_num_p1;
  assign bus.rf_data = r_rf_data_p1;

`ifdef WB_STATS_EN
  wb_starve_cnt #(
    .W   (32),
    .MAX (0),
    .SAT (1'b0)
  ) u_stat_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall),
    .i_clr (1'b0),
    .o_cnt (force_cnt),
    .o_sat ()
  );
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int DATA_W   = 32;
  localparam int NUM_W    = 5;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DATA_W), .NUM_W(NUM_W)) bus ();

`ifdef WB_STATS_EN
  logic [31:0] force_cnt;
`endif

  wb_port_arbiter #(
    .DATA_W   (DATA_W),
    .NUM_W    (NUM_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef WB_STATS_EN
    .force_cnt (force_cnt),
`endif
    .bus       (bus)
  );

  typedef struct {
    logic        rst;
    logic        pv;
    logic [4:0]  pn;
    logic [31:0] pd;
    logic        mr;
    logic [4:0]  mn;
    logic [31:0] md;
    logic        e_stall;
    logic        e_ack;
    logic        e_we;
    logic [4:0]  e_num;
    logic [31:0] e_data;
    logic        chk_nd;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  longint exp_fc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic pv, input logic [4:0] pn, input logic [31:0] pd,
                     input logic mr, input logic [4:0] mn, input logic [31:0] md,
                     input logic es, input logic ea, input logic ew,
                     input logic [4:0] en, input logic [31:0] ed, input logic cnd);
    vec_t v;
    v = '{r, pv, pn, pd, mr, mn, md, es, ea, ew, en, ed, cnd};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic pv, input logic [4:0] pn, input logic [31:0] pd,
                       input logic mr, input logic [4:0] mn, input logic [31:0] md);
    rst         = r;
    bus.p_valid = pv;
    bus.p_num   = pn;
    bus.p_data  = pd;
    bus.m_req   = mr;
    bus.m_num   = mn;
    bus.m_data  = md;
  endtask

  // Reference model state: how many consecutive cycles the pending M request
  // has been refused, plus the expected register-file port contents.
  int          wait_n;
  logic        m_we;
  logic [4:0]  m_num;
  logic [31:0] m_data;
  logic        m_known;

  initial begin
    logic        s_stall, s_ack, gp, gm;
    logic        r, pv, mr;
    logic [4:0]  pn, mn;
    logic [31:0] pd, md;
    logic        p_hold, m_hold;

    drive(1'b1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // reset with requests present: no ack, no stall, port cleared
    add(1, 1, 5'd5, 32'h5, 1, 5'd5, 32'h6,  0, 0, 0, 5'd0, 32'h0, 1);
    // P only
    add(0, 1, 5'd8, 32'h1234, 0, 0, 0,       0, 0, 1, 5'd8, 32'h1234, 1);
    // M only
    add(0, 0, 0, 0, 1, 5'd9, 32'hAAAA5555,   0, 1, 1, 5'd9, 32'hAAAA5555, 1);
    // idle: rf_we drops, num/data hold
    add(0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 5'd9, 32'hAAAA5555, 1);
    // starvation: four blocked cycles, forced on the fifth
    add(0, 1, 5'd1, 32'h11, 1, 5'd10, 32'hA0, 0, 0, 1, 5'd1, 32'h11, 1);
    add(0, 1, 5'd2, 32'h12, 1, 5'd10, 32'hA0, 0, 0, 1, 5'd2, 32'h12, 1);
    add(0, 1, 5'd3, 32'h13, 1, 5'd10, 32'hA0, 0, 0, 1, 5'd3, 32'h13, 1);
    add(0, 1, 5'd4, 32'h14, 1, 5'd10, 32'hA0, 0, 0, 1, 5'd4, 32'h14, 1);
    add(0, 1, 5'd5, 32'h15, 1, 5'd10, 32'hA0, 1, 1, 1, 5'd10, 32'hA0, 1);
    add(0, 1, 5'd5, 32'h15, 0, 0, 0,          0, 0, 1, 5'd5, 32'h15, 1);
    // same-register conflict: older M value first, then P
    add(0, 1, 5'd12, 32'h2, 1, 5'd12, 32'h1,  1, 1, 1, 5'd12, 32'h1, 1);
    add(0, 1, 5'd12, 32'h2, 0, 0, 0,          0, 0, 1, 5'd12, 32'h2, 1);
    add(0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 5'd12, 32'h2, 1);
    // register 0
    add(0, 1, 5'd0, 32'hFFFF, 0, 0, 0,        0, 0, 0, 5'd0, 32'h0, 0);
    add(0, 1, 5'd0, 32'hFFFF, 1, 5'd0, 32'h77, 0, 0, 0, 5'd0, 32'h0, 0);
    add(0, 0, 0, 0, 1, 5'd0, 32'h77,          0, 1, 0, 5'd0, 32'h0, 0);
    add(0, 1, 5'd3, 32'h33, 0, 0, 0,          0, 0, 1, 5'd3, 32'h33, 1);
    // reset mid-wait: three blocked cycles, reset, then four fresh ones
    add(0, 1, 5'd1, 32'h21, 1, 5'd10, 32'hB0, 0, 0, 1, 5'd1, 32'h21, 1);
    add(0, 1, 5'd2, 32'h22, 1, 5'd10, 32'hB0, 0, 0, 1, 5'd2, 32'h22, 1);
    add(0, 1, 5'd3, 32'h23, 1, 5'd10, 32'hB0, 0, 0, 1, 5'd3, 32'h23, 1);
    add(1, 1, 5'd4, 32'h24, 1, 5'd10, 32'hB0, 0, 0, 0, 5'd0, 32'h0, 1);
    add(0, 1, 5'd4, 32'h24, 1, 5'd10, 32'hB0, 0, 0, 1, 5'd4, 32'h24, 1);
    add(0, 1, 5'd5, 32'h25, 1, 5'd10, 32'hB0, 0, 0, 1, 5'd5, 32'h25, 1);
    add(0, 1, 5'd6, 32'h26, 1, 5'd10, 32'hB0, 0, 0, 1, 5'd6, 32'h26, 1);
    add(0, 1, 5'd7, 32'h27, 1, 5'd10, 32'hB0, 0, 0, 1, 5'd7, 32'h27, 1);
    add(0, 1, 5'd8, 32'h28, 1, 5'd10, 32'hB0, 1, 1, 1, 5'd10, 32'hB0, 1);
    add(0, 1, 5'd8, 32'h28, 0, 0, 0,          0, 0, 1, 5'd8, 32'h28, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].pv, vecs[i].pn, vecs[i].pd,
            vecs[i].mr, vecs[i].mn, vecs[i].md);
      @(negedge clk);
      chk($sformatf("vec%0d p_stall", i), bus.p_stall, vecs[i].e_stall);
      chk($sformatf("vec%0d m_ack", i), bus.m_ack, vecs[i].e_ack);
      if (vecs[i].rst) exp_fc = 0;
      else if (vecs[i].e_stall) exp_fc++;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d rf_we", i), bus.rf_we, vecs[i].e_we);
      if (vecs[i].chk_nd) begin
        chk($sformatf("vec%0d rf_num", i), bus.rf_num, vecs[i].e_num);
        chk($sformatf("vec%0d rf_data", i), bus.rf_data, vecs[i].e_data);
      end
    end

`ifdef WB_STATS_EN
    chk("force_cnt after table", force_cnt, exp_fc);
`endif

    // Randomised phase against the rule-level model. Starts from a reset.
    wait_n  = 0;
    m_we    = 0;
    m_num   = 0;
    m_data  = 0;
    m_known = 1;
    p_hold  = 0;
    m_hold  = 0;
    pv = 0; pn = 0; pd = 0; mr = 0; mn = 0; md = 0;
    for (int c = 0; c < 3000; c++) begin
      r = (c == 0) || ($urandom_range(0, 59) == 0);
      if (!p_hold) begin
        pv = ($urandom_range(0, 3) != 0);
        pn = 5'($urandom_range(0, 3));
        pd = $urandom;
      end
      if (!m_hold) begin
        mr = ($urandom_range(0, 2) == 0);
        mn = 5'($urandom_range(0, 3));
        md = $urandom;
      end
      drive(r, pv, pn, pd, mr, mn, md);

      gp = 0; gm = 0; s_stall = 0;
      if (!r) begin
        if (pv && mr && pn == mn && mn != 0)       begin gm = 1; s_stall = 1; end
        else if (pv && mr && wait_n >= MAX_WAIT)   begin gm = 1; s_stall = 1; end
        else if (pv)                               gp = 1;
        else if (mr)                               gm = 1;
      end
      s_ack = gm;

      @(negedge clk);
      chk("rand p_stall", bus.p_stall, s_stall);
      chk("rand m_ack", bus.m_ack, s_ack);

      if (r) begin
        wait_n = 0; m_we = 0; m_num = 0; m_data = 0; m_known = 1; exp_fc = 0;
      end else begin
        if (s_stall) exp_fc++;
        if (gm || !mr) wait_n = 0;
        else if (wait_n < MAX_WAIT) wait_n++;
        if (gp) begin
          m_we = (pn != 0); m_num = pn; m_data = pd; m_known = (pn != 0);
        end else if (gm) begin
          m_we = (mn != 0); m_num = mn; m_data = md; m_known = (mn != 0);
        end else begin
          m_we = 0;
        end
      end
      p_hold = pv && s_stall;
      m_hold = mr && !s_ack;

      @(posedge clk);
      #1;
      chk("rand rf_we", bus.rf_we, m_we);
      if (m_known) begin
        chk("rand rf_num", bus.rf_num, m_num);
        chk("rand rf_data", bus.rf_data, m_data);
      end
    end

`ifdef WB_STATS_EN
    chk("force_cnt after random", force_cnt, exp_fc);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
